// File: rtl/bkm_host_bus_master_if.sv
// Bundle of the command, response, slot-bus and interrupt signals of the
// BKM-68X host bus master.
//   master : view used by bkm_host_bus_master (the monitor-side initiator)
//   slave  : view used by whatever sits on the other side (card model, bench)
// Signals:
//   cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata : command handshake
//   rsp_valid/rsp_rdata                           : completion pulse, read data
//   busreset_req                                  : request a slot bus reset
//   slot_x_int_x/clk_rw/ax_d/r_wx/reset_x         : slot bus control
//   ad_out/ad_oe/ad_in                            : slot bus data
//   irq_x/irq_pending/irq_rise                    : card interrupt
interface bkm_host_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busreset_req;
  logic       slot_x_int_x;
  logic       clk_rw;
  logic       ax_d;
  logic       r_wx;
  logic       reset_x;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       irq_x;
  logic       irq_pending;
  logic       irq_rise;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, busreset_req, ad_in, irq_x,
    output cmd_ready, rsp_valid, rsp_rdata, slot_x_int_x, clk_rw, ax_d, r_wx,
           reset_x, ad_out, ad_oe, irq_pending, irq_rise
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, busreset_req, ad_in, irq_x,
    input  cmd_ready, rsp_valid, rsp_rdata, slot_x_int_x, clk_rw, ax_d, r_wx,
           reset_x, ad_out, ad_oe, irq_pending, irq_rise
  );
endinterface

// File: rtl/bkm_host_bus_master.sv
// Monitor-side initiator for the BKM-68X option-slot bus. Turns single-byte
// read/write commands into an address phase followed by a data phase, each
// made of setup / strobe / hold intervals, generates the slot bus reset and
// synchronises the card interrupt line.
// Ports:
//   clk_50mhz_in : sole clock
//   reset_in     : synchronous, active-high
//   bus          : bkm_host_bus_master_if.master (command, response, slot bus, irq)
//
// state  | meaning
// IDLE   | bus idle, cmd_ready unless a bus reset is pending
// BRST   | reset_x low for RESET_CYCLES
// A_SET  | address driven, strobe high
// A_STB  | address driven, strobe low
// A_HLD  | address driven, strobe high again
// D_SET  | data phase setup
// D_STB  | data phase strobe; read data captured on the last cycle
// D_HLD  | data phase hold
// DONE   | bus released, rsp_valid pulse
module bkm_host_bus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2,
  parameter int RESET_CYCLES  = 50
) (
  input  logic                          clk_50mhz_in,
  input  logic                          reset_in,
  bkm_host_bus_master_if.master         bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_BRST, S_A_SET, S_A_STB, S_A_HLD, S_D_SET, S_D_STB, S_D_HLD, S_DONE
  } state_t;

  // Counter reload values: a state lasting N cycles starts at N-1 and leaves at 0.
  localparam logic [7:0] SET_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STB_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] RST_LD = 8'(RESET_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;

  logic       slot_q, slot_d;
  logic       clk_rw_q, clk_rw_d;
  logic       axd_q, axd_d;
  logic       rwx_q, rwx_d;
  logic       rstx_q, rstx_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       rsp_q, rsp_d;

  logic       irq_s1_q, irq_s2_q, irq_s3_q;

  logic       tc;
  logic       pend_any;

  assign tc       = (cnt_q == 8'd0);
  // A request arriving in the same cycle as a command must already win.
  assign pend_any = pend_q | bus.busreset_req;

  assign bus.cmd_ready = (state_q == S_IDLE) & ~pend_any & ~reset_in;

  // State and output registers
  always_ff @(posedge clk_50mhz_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      pend_q   <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= 8'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      slot_q   <= 1'b1;
      clk_rw_q <= 1'b1;
      axd_q    <= 1'b1;
      rwx_q    <= 1'b1;
      rstx_q   <= 1'b1;
      ad_out_q <= 8'd0;
      ad_oe_q  <= 1'b0;
      rsp_q    <= 1'b0;
      irq_s1_q <= 1'b1;
      irq_s2_q <= 1'b1;
      irq_s3_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      slot_q   <= slot_d;
      clk_rw_q <= clk_rw_d;
      axd_q    <= axd_d;
      rwx_q    <= rwx_d;
      rstx_q   <= rstx_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      rsp_q    <= rsp_d;
      irq_s1_q <= bus.irq_x;
      irq_s2_q <= irq_s1_q;
      irq_s3_q <= irq_s2_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    pend_d  = pend_any;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_any) begin
          state_d = S_BRST;
          cnt_d   = RST_LD;
        end else if (bus.cmd_valid) begin
          state_d = S_A_SET;
          cnt_d   = SET_LD;
          rw_d    = bus.cmd_rw;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
        end
      end
      S_BRST: begin
        if (tc) begin
          state_d = S_IDLE;
          pend_d  = bus.busreset_req;
        end
      end
      S_A_SET: if (tc) begin state_d = S_A_STB; cnt_d = STB_LD; end
      S_A_STB: if (tc) begin state_d = S_A_HLD; cnt_d = HLD_LD; end
      S_A_HLD: if (tc) begin state_d = S_D_SET; cnt_d = SET_LD; end
      S_D_SET: if (tc) begin state_d = S_D_STB; cnt_d = STB_LD; end
      S_D_STB: begin
        if (tc) begin
          state_d = S_D_HLD;
          cnt_d   = HLD_LD;
          if (rw_q) rdata_d = bus.ad_in;
        end
      end
      S_D_HLD: if (tc) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: decoded from the next state so the bus pins come straight
  // from flops and line up with state_q.
  always_comb begin
    slot_d   = 1'b1;
    clk_rw_d = 1'b1;
    axd_d    = 1'b1;
    rwx_d    = 1'b1;
    rstx_d   = 1'b1;
    ad_out_d = 8'd0;
    ad_oe_d  = 1'b0;
    rsp_d    = 1'b0;
    unique case (state_d)
      S_BRST: rstx_d = 1'b0;
      S_A_SET, S_A_STB, S_A_HLD: begin
        slot_d   = 1'b0;
        axd_d    = 1'b1;
        rwx_d    = rw_d;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        clk_rw_d = (state_d != S_A_STB);
      end
      S_D_SET, S_D_STB, S_D_HLD: begin
        slot_d   = 1'b0;
        axd_d    = 1'b0;
        rwx_d    = rw_d;
        ad_oe_d  = ~rw_d;
        ad_out_d = rw_d ? 8'd0 : wdata_d;
        clk_rw_d = (state_d != S_D_STB);
      end
      S_DONE:  rsp_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_valid    = rsp_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.slot_x_int_x = slot_q;
  assign bus.clk_rw       = clk_rw_q;
  assign bus.ax_d         = axd_q;
  assign bus.r_wx         = rwx_q;
  assign bus.reset_x      = rstx_q;
  assign bus.ad_out       = ad_out_q;
  assign bus.ad_oe        = ad_oe_q;
  // irq_x is active-low; s3 is s2 one cycle late, giving the rising pulse.
  assign bus.irq_pending  = ~irq_s2_q;
  assign bus.irq_rise     = ~irq_s2_q & irq_s3_q;

endmodule

// File: tb/tb_bkm_host_bus_master.sv
module tb_bkm_host_bus_master;
  localparam int S   = 2;
  localparam int T   = 4;
  localparam int H   = 2;
  localparam int R   = 50;
  localparam int P   = S + T + H;
  localparam int LAT = 2 * P + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] card_q = 8'h00;
  logic [7:0] last_rd = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  bkm_host_bus_master_if bus_if ();

  bkm_host_bus_master #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H), .RESET_CYCLES(R)
  ) dut (
    .clk_50mhz_in(clk),
    .reset_in    (rst),
    .bus         (bus_if.master)
  );

  always #10 clk = ~clk;

  // Card model: drives its data only while the data-phase strobe is low.
  assign bus_if.ad_in = (!bus_if.clk_rw && !bus_if.ax_d) ? card_q : 8'h3C;

  localparam logic [14:0] IDLE_BUS = {7'b1111100, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {slot, clk_rw, ax_d, r_wx, reset_x, ad_oe, rsp_valid, ad_out}
  function automatic logic [14:0] obs_bus();
    return {bus_if.slot_x_int_x, bus_if.clk_rw, bus_if.ax_d, bus_if.r_wx,
            bus_if.reset_x, bus_if.ad_oe, bus_if.rsp_valid, bus_if.ad_out};
  endfunction

  // Expected bus pins k cycles after the handshake cycle.
  function automatic logic [14:0] exp_bus(int k, logic rw, logic [7:0] addr, logic [7:0] wdata);
    int  ph, j;
    logic strobe;
    if (k == LAT) return {7'b1111101, 8'h00};
    ph = (k - 1) / P;
    j  = (k - 1) % P;
    strobe = (j >= S) && (j < S + T);
    if (ph == 0) return {1'b0, ~strobe, 1'b1, rw, 1'b1, 1'b1, 1'b0, addr};
    return {1'b0, ~strobe, 1'b0, rw, 1'b1, ~rw, 1'b0, (rw ? 8'h00 : wdata)};
  endfunction

  task automatic run_txn(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] card);
    @(negedge clk);
    bus_if.cmd_rw    = rw;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    bus_if.cmd_valid = 1'b1;
    card_q           = card;
    #1 chk("txn_ready", 32'(bus_if.cmd_ready), 32'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      chk($sformatf("txn_bus_k%0d", k), 32'(obs_bus()), 32'(exp_bus(k, rw, addr, wdata)));
    end
    if (rw) last_rd = card;
    chk("txn_rdata", 32'(bus_if.rsp_rdata), 32'(last_rd));
    @(negedge clk);
    chk("txn_rsp_single", 32'(bus_if.rsp_valid), 32'd0);
  endtask

  initial begin
    int hs, cyc, rsp_cnt, falls, low_cnt, lat, rise_cnt;
    int hs_cyc[3];
    logic prev_slot, hs_done, found;

    bus_if.cmd_valid    = 1'b0;
    bus_if.cmd_rw       = 1'b0;
    bus_if.cmd_addr     = 8'h00;
    bus_if.cmd_wdata    = 8'h00;
    bus_if.busreset_req = 1'b0;
    bus_if.irq_x        = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_bus", 32'(obs_bus()), 32'(IDLE_BUS));
    chk("rst_ready", 32'(bus_if.cmd_ready), 32'd0);
    chk("rst_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    chk("rst_irq", 32'({bus_if.irq_pending, bus_if.irq_rise}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus_if.cmd_ready), 32'd1);

    // Directed write and read
    run_txn(1'b0, 8'h3A, 8'h12, 8'h00);
    run_txn(1'b1, 8'h05, 8'h00, 8'hA5);

    // Random transactions
    for (int i = 0; i < 6; i++)
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));

    // Back-to-back writes with cmd_valid held
    hs = 0; cyc = 0; rsp_cnt = 0; falls = 0; prev_slot = 1'b1;
    bus_if.cmd_rw    = 1'b0;
    bus_if.cmd_addr  = 8'h77;
    while (cyc < 120 && !(hs == 3 && rsp_cnt == 3)) begin
      @(negedge clk);
      if (bus_if.rsp_valid) rsp_cnt++;
      if (prev_slot && !bus_if.slot_x_int_x) falls++;
      prev_slot = bus_if.slot_x_int_x;
      bus_if.cmd_valid = (hs < 3);
      bus_if.cmd_wdata = 8'h40 + 8'(hs);
      #1;
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        hs_cyc[hs] = cyc;
        hs++;
      end
      cyc++;
    end
    bus_if.cmd_valid = 1'b0;
    chk("b2b_handshakes", 32'(hs), 32'd3);
    chk("b2b_rsp_count", 32'(rsp_cnt), 32'd3);
    chk("b2b_bus_cycles", 32'(falls), 32'd3);
    chk("b2b_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'(LAT + 1));
    chk("b2b_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'(LAT + 1));
    repeat (2) @(negedge clk);

    // Bus reset request together with a command
    bus_if.cmd_rw       = 1'b0;
    bus_if.cmd_addr     = 8'h11;
    bus_if.cmd_wdata    = 8'h22;
    bus_if.cmd_valid    = 1'b1;
    bus_if.busreset_req = 1'b1;
    #1 chk("brst_ready_blocked", 32'(bus_if.cmd_ready), 32'd0);
    hs = 0; rsp_cnt = 0; low_cnt = 0; cyc = 0; hs_done = 1'b0;
    while (cyc < 200 && !(rsp_cnt >= 1 && cyc > 100)) begin
      @(negedge clk);
      bus_if.busreset_req = 1'b0;
      if (hs_done) bus_if.cmd_valid = 1'b0;
      if (!bus_if.reset_x) low_cnt++;
      if (bus_if.rsp_valid) begin
        rsp_cnt++;
        chk("brst_rsp_after_hs", 32'(hs), 32'd1);
      end
      #1;
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        hs++;
        hs_done = 1'b1;
        chk("brst_hs_after_reset", 32'(low_cnt), 32'(R));
      end
      cyc++;
    end
    bus_if.cmd_valid = 1'b0;
    chk("brst_low_cycles", 32'(low_cnt), 32'(R));
    chk("brst_hs_count", 32'(hs), 32'd1);
    chk("brst_rsp_count", 32'(rsp_cnt), 32'd1);

    // Interrupt synchroniser
    @(negedge clk);
    #3 bus_if.irq_x = 1'b0;
    lat = 0; rise_cnt = 0; found = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_if.irq_rise) rise_cnt++;
      if (!found && bus_if.irq_pending) begin
        found = 1'b1;
        lat = i;
      end
    end
    chk("irq_seen", 32'(found), 32'd1);
    chk("irq_latency_ok", 32'(lat >= 2 && lat <= 3), 32'd1);
    chk("irq_rise_once", 32'(rise_cnt), 32'd1);
    bus_if.irq_x = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!bus_if.irq_pending) found = 1'b1;
    end
    chk("irq_cleared", 32'(found), 32'd1);
    chk("irq_rise_quiet", 32'(bus_if.irq_rise), 32'd0);

    // Reset during the address strobe
    @(negedge clk);
    bus_if.cmd_rw    = 1'b1;
    bus_if.cmd_addr  = 8'h09;
    bus_if.cmd_valid = 1'b1;
    card_q           = 8'h5A;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      if (!bus_if.clk_rw && bus_if.ax_d) found = 1'b1;
    end
    chk("mid_reached_astb", 32'(found), 32'd1);
    rst = 1'b1;
    #1 chk("mid_ready_in_reset", 32'(bus_if.cmd_ready), 32'd0);
    @(negedge clk);
    chk("mid_rst_bus", 32'(obs_bus()), 32'(IDLE_BUS));
    chk("mid_rst_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    chk("mid_rst_irq", 32'({bus_if.irq_pending, bus_if.irq_rise}), 32'd0);
    rst = 1'b0;
    last_rd = 8'h00;
    rsp_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) rsp_cnt++;
    end
    chk("mid_no_rsp", 32'(rsp_cnt), 32'd0);
    run_txn(1'b1, 8'h05, 8'h00, 8'hC7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
